rs_c1_encoder: RTL and testbench

Systematic Reed-Solomon encoder over GF(256) for the CD C1 code, RS(32,28) by default. It is the transmit-side counterpart of the RS decoding path, used to build self-test stimulus and to loop back into the decoder. The block accepts K message bytes, passes them through unchanged, and then appends NSYM parity bytes. The parity is computed by a byte-serial LFSR division by the generator polynomial.

---
 rtl/rs_pkg.sv | 11 +
 rtl/rs_c1_encoder_if.sv | 15 +
 rtl/gf256_mult.sv | 21 ++
 rtl/rs_c1_encoder.sv | 95 +++++++++
 tb/tb_rs_c1_encoder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon constants for the CD C1 code over GF(256), field poly 0x11D.
package rs_pkg;
  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int         C1_K    = 28;
  localparam int         C1_NSYM = 4;

  // g(x) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40, low-order coefficient first
  localparam logic [0:3][7:0] RS_C1_GEN = {8'h40, 8'h78, 8'h36, 8'h0F};

  typedef enum logic [1:0] {IDLE, DATA, PARITY} rs_state_e;
endpackage

// File: rtl/rs_c1_encoder_if.sv
// Byte-stream handshake between a message source and the C1 encoder.
interface rs_c1_encoder_if;
  logic       i_start;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_last;

  modport master (output i_start, i_valid, i_data,
                  input  o_ready, o_valid, o_data, o_last);
  modport slave  (input  i_start, i_valid, i_data,
                  output o_ready, o_valid, o_data, o_last);
endinterface

// File: rtl/gf256_mult.sv
// Combinational GF(256) multiplier; a constant operand folds to an XOR network.
module gf256_mult
  import rs_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY) : {sh[6:0], 1'b0};
    end
    p = acc;
  end
endmodule

// File: rtl/rs_c1_encoder.sv
// Systematic RS(K+NSYM,K) encoder: echoes message bytes, then shifts out the
// remainder of m(x)*x^NSYM / g(x) held in a byte-serial LFSR.
module rs_c1_encoder
  import rs_pkg::*;
#(
  parameter int K    = C1_K,
  parameter int NSYM = C1_NSYM
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  rs_c1_encoder_if.slave   bus
);
  rs_state_e                  state_q, state_d;
  logic [NSYM-1:0][7:0]       p_q, p_d;
  logic [NSYM-1:0][7:0]       fb_prod;
  logic [7:0]                 cnt_q, cnt_d;
  logic [7:0]                 o_data_q, o_data_d;
  logic                       o_valid_q, o_valid_d;
  logic                       o_last_q, o_last_d;
  logic [7:0]                 fb;

  assign fb = bus.i_data ^ p_q[NSYM-1];

  for (genvar g = 0; g < NSYM; g++) begin : g_mul
    gf256_mult u_mul (.a(fb), .b(RS_C1_GEN[g]), .p(fb_prod[g]));
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    o_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          p_d     = '0;
          cnt_d   = 8'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.i_valid) begin
          p_d[0] = fb_prod[0];
          for (int i = 1; i < NSYM; i++) p_d[i] = p_q[i-1] ^ fb_prod[i];
          o_data_d  = bus.i_data;
          o_valid_d = 1'b1;
          if (cnt_q == 8'(K-1)) begin
            cnt_d   = 8'd0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      PARITY: begin
        o_data_d  = p_q[NSYM-1];
        o_valid_d = 1'b1;
        p_d       = {p_q[NSYM-2:0], 8'h00};
        if (cnt_q == 8'(NSYM-1)) begin
          o_last_d = 1'b1;
          cnt_d    = 8'd0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      cnt_q     <= 8'd0;
      o_data_q  <= 8'h00;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
    end
  end

  assign bus.o_ready = (state_q == DATA);
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_last  = o_last_q;
endmodule

// File: tb/tb_rs_c1_encoder.sv
// Bench for rs_c1_encoder: polynomial-division reference, per-cycle output
// compare, and syndrome check of every completed codeword.
module tb_rs_c1_encoder;
  localparam int K = 28, NSYM = 4, N = K + NSYM;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_c1_encoder_if bus ();
  rs_c1_encoder #(.K(K), .NSYM(NSYM)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;

  logic       nxt_v = 0, nxt_l = 0, nxt_r = 0;
  logic [7:0] nxt_d = 0;
  bit         chk_en = 0;
  logic [7:0] gen [0:NSYM];
  logic [7:0] msg [K];
  logic [7:0] cw_exp [N];
  logic [7:0] cap [N];
  int         cap_n = 0;
  longint     last_t = 0, prev_t = 0;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1D) : (a << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] apow(int e);
    logic [7:0] r = 8'h01;
    repeat (e) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // g(x) = prod (x + a^i), coefficients highest degree first
  task automatic build_gen();
    logic [7:0] t [0:NSYM];
    gen[0] = 8'h01;
    for (int j = 1; j <= NSYM; j++) gen[j] = 8'h00;
    for (int i = 0; i < NSYM; i++) begin
      for (int j = 0; j <= NSYM; j++) t[j] = gen[j] ^ ((j > 0) ? gmul(apow(i), gen[j-1]) : 8'h00);
      for (int j = 0; j <= NSYM; j++) gen[j] = t[j];
    end
  endtask

  // codeword = msg followed by remainder of msg(x)*x^NSYM mod g(x)
  task automatic model_encode();
    logic [7:0] d [N];
    for (int i = 0; i < N; i++) d[i] = (i < K) ? msg[i] : 8'h00;
    for (int i = 0; i < K; i++) begin
      logic [7:0] c;
      c = d[i];
      for (int j = 1; j <= NSYM; j++) d[i+j] = d[i+j] ^ gmul(c, gen[j]);
    end
    for (int i = 0; i < N; i++) cw_exp[i] = (i < K) ? msg[i] : d[i];
  endtask

  function automatic logic [7:0] syndrome(int j);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < N; i++) s = gmul(s, apow(j)) ^ cap[i];
    return s;
  endfunction

  initial begin : compare
    logic ev, el, er;
    logic [7:0] ed;
    forever begin
      @(posedge clk);
      ev = nxt_v; el = nxt_l; er = nxt_r; ed = nxt_d;
      @(negedge clk);
      if (chk_en) begin
        check("o_valid", bus.o_valid, ev);
        check("o_ready", bus.o_ready, er);
        check("o_last", bus.o_last, ev & el);
        if (ev) check("o_data", bus.o_data, ed);
      end
      if (!rst_n) cap_n = 0;
      else if (bus.o_valid) begin
        if (cap_n < N) cap[cap_n] = bus.o_data;
        cap_n++;
        if (bus.o_last) begin
          prev_t = last_t;
          last_t = $time;
          check("cw_len", cap_n, N);
          if (cap_n == N)
            for (int j = 0; j < NSYM; j++) check($sformatf("syndrome%0d", j), syndrome(j), 0);
          cap_n = 0;
        end
      end
    end
  end

  task automatic cycle(bit st, bit v, logic [7:0] d, bit ev, logic [7:0] ed, bit el, bit er);
    @(posedge clk);
    #1;
    bus.i_start = st; bus.i_valid = v; bus.i_data = d;
    nxt_v = ev; nxt_d = ed; nxt_l = el; nxt_r = er;
  endtask

  task automatic idle(int n, bit junk);
    repeat (n) cycle(1'b0, junk, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // abort_at >= 0 stops after that many accepted message bytes
  task automatic run_cw(int gap_max, bit junk, int abort_at);
    model_encode();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < K; i++) begin
      if (i == abort_at) return;
      repeat ($urandom_range(gap_max, 0))
        cycle(junk & 1'($urandom), 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b1);
      cycle(junk & 1'($urandom), 1'b1, msg[i], 1'b1, msg[i], 1'b0, i != K-1);
    end
    for (int j = 0; j < NSYM; j++)
      cycle(junk, junk, 8'($urandom), 1'b1, cw_exp[K+j], j == NSYM-1, 1'b0);
  endtask

  task automatic rand_msg();
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    bus.i_start = 0; bus.i_valid = 0; bus.i_data = 0;
    build_gen();
    check("gen3", gen[1], 8'h0F);
    check("gen2", gen[2], 8'h36);
    check("gen1", gen[3], 8'h78);
    check("gen0", gen[4], 8'h40);
    check("gmul_wrap", gmul(8'h80, 8'h02), 8'h1D);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_ready", bus.o_ready, 0);
    check("rst_o_last", bus.o_last, 0);
    check("rst_o_data", bus.o_data, 0);
    rst_n = 1'b1;
    #1 chk_en = 1'b1;
    idle(2, 1'b0);

    // all-zero message
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    run_cw(0, 1'b0, -1);
    idle(2, 1'b0);

    // single unit coefficient: parity equals g(x) low coefficients
    for (int i = 0; i < K; i++) msg[i] = (i == K-1) ? 8'h01 : 8'h00;
    model_encode();
    check("pin_par0", cw_exp[K],   8'h0F);
    check("pin_par1", cw_exp[K+1], 8'h36);
    check("pin_par2", cw_exp[K+2], 8'h78);
    check("pin_par3", cw_exp[K+3], 8'h40);
    run_cw(0, 1'b0, -1);
    idle(3, 1'b1);

    // random message with gaps, then with ignored start/valid noise
    rand_msg();
    run_cw(3, 1'b0, -1);
    idle(3, 1'b1);
    rand_msg();
    run_cw(2, 1'b1, -1);
    idle(3, 1'b1);

    // reset mid-codeword after 10 bytes
    rand_msg();
    run_cw(1, 1'b0, 10);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_o_valid", bus.o_valid, 0);
    check("arst_o_ready", bus.o_ready, 0);
    check("arst_o_last", bus.o_last, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_msg();
    run_cw(1, 1'b0, -1);
    idle(2, 1'b0);

    // back-to-back codewords, second start in the o_last cycle
    rand_msg();
    run_cw(0, 1'b0, -1);
    rand_msg();
    run_cw(0, 1'b0, -1);
    idle(3, 1'b0);
    check("b2b_period", 32'((last_t - prev_t) / 10), 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
